// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//   - OP_* : shift operation codes carried on in_op.
//   - state_e : sequencer FSM states.
package shift_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;  // logical left
    localparam logic [1:0] OP_SRL = 2'b01;  // logical right
    localparam logic [1:0] OP_SRA = 2'b10;  // arithmetic right
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift step.
// Ports:
//   op : shift operation (shift_pkg OP_* codes)
//   d  : value before the step
//   q  : value after one bit of shift/rotate
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_comb begin
        q = d;
        case (op)
            OP_SLL:  q = {d[WIDTH-2:0], 1'b0};
            OP_SRL:  q = {1'b0, d[WIDTH-1:1]};
            OP_SRA:  q = {d[WIDTH-1], d[WIDTH-1:1]};
            OP_ROR:  q = {d[0], d[WIDTH-1:1]};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift unit: accepts (operand, op, amount) over a valid/ready
// handshake, applies one single-bit step per clock, then presents the result
// over a valid/ready output handshake.
// Ports:
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   in_valid  : command valid
//   in_ready  : high in IDLE; command accepted on in_valid && in_ready
//   in_op     : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   in_amt    : requested shift amount
//   in_data   : operand
//   out_valid : result valid (DONE state)
//   out_ready : consumer ready; result consumed on out_valid && out_ready
//   out_data  : working register (final result while out_valid)
//   busy      : high in SHIFT or DONE
module shift_sequencer
    import shift_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam logic [AMT_W-1:0] WIDTH_AMT = AMT_W'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [1:0]       op_q, op_d;
    logic [AMT_W-1:0] count_q, count_d;
    logic [AMT_W-1:0] eff_amt;
    logic [WIDTH-1:0] step_q;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .op (op_q),
        .d  (work_q),
        .q  (step_q)
    );

    // Rotation is periodic in WIDTH; the other shifts saturate at WIDTH
    // (everything has been shifted out, or replaced by the sign bit).
    always_comb begin
        eff_amt = in_amt;
        if (in_op == OP_ROR) begin
            eff_amt = in_amt % WIDTH_AMT;
        end else if (in_amt > WIDTH_AMT) begin
            eff_amt = WIDTH_AMT;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        op_d    = op_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    op_d    = in_op;
                    count_d = eff_amt;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A zero-amount command passes through here for one cycle
                // without stepping, so every command has latency max(N,1).
                if (count_q != '0) begin
                    work_d  = step_q;
                    count_d = count_q - AMT_W'(1);
                end
                if (count_q <= AMT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            work_q  <= '0;
            op_q    <= OP_SLL;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            op_q    <= op_d;
            count_q <= count_d;
        end
    end

    // Handshake outputs decode registered state only.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_data  = work_q;

endmodule

// File: tb/tb_shift_sequencer.sv
module tb_shift_sequencer;

    localparam int W  = 4;
    localparam int AW = $clog2(W) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_op = 2'b00;
    logic [AW-1:0] in_amt = '0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [W-1:0]  out_data;
    logic          busy;

    int checks = 0;
    int errors = 0;

    shift_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference arithmetic: effective amount and final result of a command.
    function automatic int eff_n(input logic [1:0] op, input int amt);
        if (op == 2'b11) return amt % W;
        return (amt > W) ? W : amt;
    endfunction

    function automatic logic [W-1:0] ref_result(input logic [1:0] op, input int amt,
                                                input logic [W-1:0] d);
        int n;
        logic [2*W-1:0] dd;
        logic signed [W-1:0] sd;
        n  = eff_n(op, amt);
        dd = {d, d};
        sd = d;
        case (op)
            2'b00:   return W'((d << n) & {W{1'b1}});
            2'b01:   return d >> n;
            2'b10:   return W'(sd >>> n);
            default: return dd[W-1:0] >> 0 == 0 ? W'(dd >> n) : W'(dd >> n);
        endcase
    endfunction

    // Behavioural model: idle / working (countdown) / result-ready.
    int           m_phase = 0;
    int           m_wait  = 0;
    logic [W-1:0] m_res   = '0;
    logic [W-1:0] m_data  = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase <= 0;
            m_wait  <= 0;
            m_data  <= '0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_res   <= ref_result(in_op, int'(in_amt), in_data);
                    m_wait  <= (eff_n(in_op, int'(in_amt)) > 1) ? eff_n(in_op, int'(in_amt)) : 1;
                    m_phase <= 1;
                end
                1: begin
                    m_wait <= m_wait - 1;
                    if (m_wait == 1) begin
                        m_phase <= 2;
                        m_data  <= m_res;
                    end
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("in_ready", int'(in_ready), int'(m_phase == 0));
            chk("out_valid", int'(out_valid), int'(m_phase == 2));
            chk("busy", int'(busy), int'(m_phase != 0));
            if (m_phase != 1) chk("out_data", int'(out_data), int'(m_data));
        end
    end

    // Issue one command with out_ready=1, check hand-computed result and latency.
    task automatic run_cmd(input string nm, input logic [1:0] op, input int amt,
                           input logic [W-1:0] d, input logic [W-1:0] exp_d,
                           input int exp_lat);
        int lat;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({nm, "_ready_before"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_op    = op;
        in_amt   = AW'(amt);
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble command inputs while shifting; they must be ignored.
        in_op    = ~op;
        in_amt   = AW'(amt + 1);
        in_data  = ~d;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, exp_lat);
        chk({nm, "_data"}, int'(out_data), int'(exp_d));
        @(posedge clk); #1;
        chk({nm, "_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_out_data", int'(out_data), 0);

        run_cmd("sll1",   2'b00, 1, 4'b1010, 4'b0100, 1);
        run_cmd("sra2",   2'b10, 2, 4'b1010, 4'b1110, 2);
        run_cmd("srl2",   2'b01, 2, 4'b1010, 4'b0010, 2);
        run_cmd("ror5",   2'b11, 5, 4'b1101, 4'b1110, 1);
        run_cmd("ror4",   2'b11, 4, 4'b1101, 4'b1101, 1);
        run_cmd("srl6",   2'b01, 6, 4'b1101, 4'b0000, 4);
        run_cmd("sll0",   2'b00, 0, 4'b0110, 4'b0110, 1);
        run_cmd("sra7",   2'b10, 7, 4'b1001, 4'b1111, 4);
        run_cmd("sll4",   2'b00, 4, 4'b0001, 4'b0000, 4);
        run_cmd("ror3",   2'b11, 3, 4'b1001, 4'b0011, 3);

        // Backpressure
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'b00; in_amt = AW'(1); in_data = 4'b0011;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_valid", int'(out_valid), 1);
        chk("bp_data", int'(out_data), 4'b0110);
        in_valid = 1'b1; in_op = 2'b01; in_amt = AW'(1); in_data = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", int'(out_valid), 1);
            chk("bp_hold_data", int'(out_data), 4'b0110);
            chk("bp_hold_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_consumed", int'(out_valid), 0);
        chk("bp_no_accept", int'(busy), 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("bp_idle", int'(busy), 0);
        chk("bp_last_data", int'(out_data), 4'b0110);

        // Asynchronous reset mid-shift
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = 2'b00; in_amt = AW'(3); in_data = 4'b1111;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("ar_busy_before", int'(busy), 1);
        #2 rst = 1'b0;
        #1;
        chk("ar_out_valid", int'(out_valid), 0);
        chk("ar_out_data", int'(out_data), 0);
        chk("ar_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        run_cmd("srl3", 2'b01, 3, 4'b1000, 4'b0001, 3);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
